// File: rtl/frmpool_ctrl.sv
// Frame-pool controller: streams words through a single-port SRAM and re-times
// the one-cycle read latency into a 3-entry output FIFO feeding a valid/ready port.
module frmpool_ctrl #(
   parameter int SRAM_DEPTH_BIT = 6,
   parameter int SRAM_DEPTH     = 2**SRAM_DEPTH_BIT,
   parameter int SRAM_WIDTH     = 28
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_vld,
   output logic                      in_rdy,
   input  logic [SRAM_WIDTH-1:0]     in_data,
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [SRAM_WIDTH-1:0]     out_data,
   output logic                      sram_write_en,
   output logic                      sram_read_en,
   output logic [SRAM_DEPTH_BIT-1:0] sram_addr_w,
   output logic [SRAM_DEPTH_BIT-1:0] sram_addr_r,
   output logic [SRAM_WIDTH-1:0]     sram_data_in,
   input  logic [SRAM_WIDTH-1:0]     sram_data_out,
   output logic [SRAM_DEPTH_BIT:0]   count,
   output logic                      full,
   output logic                      empty
);
   localparam int CW = SRAM_DEPTH_BIT + 1;
   localparam logic [SRAM_DEPTH_BIT-1:0] PTR_LAST = SRAM_DEPTH_BIT'(SRAM_DEPTH - 1);
   localparam logic [CW-1:0]             CNT_FULL = CW'(SRAM_DEPTH);

   logic [SRAM_DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
   logic [SRAM_DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             count_q, count_d;
   logic                      inflight_q;
   logic                      rr_q, rr_d;
   logic [SRAM_WIDTH-1:0]     obuf_q [3];
   logic [1:0]                obuf_head_q, obuf_head_d;
   logic [1:0]                obuf_tail_q, obuf_tail_d;
   logic [1:0]                obuf_cnt_q, obuf_cnt_d;
   logic [2:0]                pending;
   logic                      wr_req, rd_req, rd_wins;
   logic                      wr_gnt, rd_gnt;
   logic                      obuf_push, obuf_pop;

   function automatic logic [1:0] obuf_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Reads are throttled by registered occupancy only, so out_rdy never reaches sram_read_en.
   assign full    = (count_q == CNT_FULL);
   assign pending = {1'b0, obuf_cnt_q} + {2'b00, inflight_q};
   assign wr_req  = in_vld & ~full;
   assign rd_req  = (count_q != '0) & (pending < 3'd3);
   assign rd_wins = rd_req & (rr_q | ~wr_req);
   assign in_rdy  = rst_n & ~full & ~rd_wins;
   assign wr_gnt  = in_vld & in_rdy;
   assign rd_gnt  = rst_n & rd_wins;

   assign sram_write_en = wr_gnt;
   assign sram_read_en  = rd_gnt;
   assign sram_addr_w   = wr_ptr_q;
   assign sram_addr_r   = rd_ptr_q;
   assign sram_data_in  = in_data;
   assign count         = count_q;
   assign empty         = (count_q == '0) & ~inflight_q & (obuf_cnt_q == 2'd0);

   assign out_vld   = (obuf_cnt_q != 2'd0);
   assign obuf_push = inflight_q;
   assign obuf_pop  = out_vld & out_rdy;

   always_comb begin
      case (obuf_head_q)
         2'd1:    out_data = obuf_q[1];
         2'd2:    out_data = obuf_q[2];
         default: out_data = obuf_q[0];
      endcase
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rr_d        = rr_q;
      obuf_head_d = obuf_head_q;
      obuf_tail_d = obuf_tail_q;
      obuf_cnt_d  = obuf_cnt_q;

      if (wr_gnt) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         count_d  = count_q + 1'b1;
         rr_d     = 1'b1;
      end else if (rd_gnt) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         count_d  = count_q - 1'b1;
         rr_d     = 1'b0;
      end

      if (obuf_push) obuf_tail_d = obuf_inc(obuf_tail_q);
      if (obuf_pop)  obuf_head_d = obuf_inc(obuf_head_q);
      case ({obuf_push, obuf_pop})
         2'b10:   obuf_cnt_d = obuf_cnt_q + 2'd1;
         2'b01:   obuf_cnt_d = obuf_cnt_q - 2'd1;
         default: obuf_cnt_d = obuf_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         inflight_q  <= 1'b0;
         rr_q        <= 1'b0;
         obuf_head_q <= 2'd0;
         obuf_tail_q <= 2'd0;
         obuf_cnt_q  <= 2'd0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         inflight_q  <= rd_gnt;
         rr_q        <= rr_d;
         obuf_head_q <= obuf_head_d;
         obuf_tail_q <= obuf_tail_d;
         obuf_cnt_q  <= obuf_cnt_d;
      end
   end

   // Payload storage needs no reset; validity is carried by obuf_cnt_q.
   always_ff @(posedge clk) begin
      if (obuf_push) begin
         for (int i = 0; i < 3; i++) begin
            if (obuf_tail_q == 2'(i)) obuf_q[i] <= sram_data_out;
         end
      end
   end

endmodule

// File: tb/tb_frmpool_ctrl.sv
// Bench for frmpool_ctrl: SRAM behavioural model, queue scoreboard and directed plus random phases.
module tb_frmpool_ctrl;
   localparam int DB    = 6;
   localparam int DEPTH = 64;
   localparam int W     = 28;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_vld = 1'b0;
   logic          out_rdy = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_rdy, out_vld, sram_write_en, sram_read_en, full, empty;
   logic [W-1:0]  out_data, sram_data_in;
   logic [W-1:0]  sram_data_out;
   logic [DB-1:0] sram_addr_w, sram_addr_r;
   logic [DB:0]   count;

   frmpool_ctrl #(.SRAM_DEPTH_BIT(DB), .SRAM_DEPTH(DEPTH), .SRAM_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
      .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
      .sram_addr_w(sram_addr_w), .sram_addr_r(sram_addr_r),
      .sram_data_in(sram_data_in), .sram_data_out(sram_data_out),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   logic [W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (sram_write_en) mem[sram_addr_w] <= sram_data_in;
      if (sram_read_en)  sram_data_out <= mem[sram_addr_r];
   end

   int checks = 0;
   int failures = 0;
   logic [W-1:0] model_q[$];
   int cyc = 0, first_push = -1, first_vld = -1, n_pops = 0;
   int seqv = 1;
   bit did_push, did_pop, hold_prev, last_we, last_re;
   logic [W-1:0] data_prev;
   bit waddr_ok, raddr_ok;
   int last_waddr, last_raddr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      model_q.delete();
      hold_prev = 0;
      waddr_ok = 0;
      raddr_ok = 0;
   endtask

   // One clock: inputs already driven at posedge+1, sampled at posedge+3.
   task automatic cycle();
      #2;
      did_push = in_vld && in_rdy;
      did_pop  = out_vld && out_rdy;
      last_we  = sram_write_en;
      last_re  = sram_read_en;
      chk("no_overlap", 64'(sram_write_en & sram_read_en), 0);
      chk("write_is_push", 64'(sram_write_en), 64'(did_push));
      chk("count_bound", 64'(count > DEPTH), 0);
      if (full) chk("full_blocks_input", {62'd0, in_rdy, sram_write_en}, 0);
      if (hold_prev) chk("hold_data", 64'(out_data), 64'(data_prev));
      if (sram_write_en) begin
         if (waddr_ok) chk("waddr_seq", 64'(sram_addr_w), 64'((last_waddr + 1) % DEPTH));
         last_waddr = int'(sram_addr_w);
         waddr_ok = 1;
      end
      if (sram_read_en) begin
         if (raddr_ok) chk("raddr_seq", 64'(sram_addr_r), 64'((last_raddr + 1) % DEPTH));
         last_raddr = int'(sram_addr_r);
         raddr_ok = 1;
      end
      if (did_pop) begin
         chk("spurious_pop", 64'(model_q.size() == 0), 0);
         if (model_q.size() != 0) chk("pop_data", 64'(out_data), 64'(model_q.pop_front()));
         n_pops++;
      end
      if (did_push) begin
         model_q.push_back(in_data);
         if (first_push < 0) first_push = cyc;
      end
      if (out_vld && first_vld < 0) first_vld = cyc;
      hold_prev = out_vld && !out_rdy;
      data_prev = out_data;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push_n(input int n, input int budget);
      int got = 0;
      int t = 0;
      while (got < n && t < budget) begin
         in_vld  = 1'b1;
         in_data = W'(seqv);
         cycle();
         if (did_push) begin
            got++;
            seqv++;
         end
         t++;
      end
      in_vld = 1'b0;
      chk("push_budget", 64'(got), 64'(n));
   endtask

   task automatic drain(input int budget);
      int t = 0;
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      while ((model_q.size() != 0 || empty !== 1'b1) && t < budget) begin
         cycle();
         t++;
      end
      chk("drain_model", 64'(model_q.size()), 0);
      chk("drain_empty", 64'(empty), 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      $display("reset check %s", tag);
      chk({tag, "_in_rdy"}, 64'(in_rdy), 0);
      chk({tag, "_out_vld"}, 64'(out_vld), 0);
      chk({tag, "_we"}, 64'(sram_write_en), 0);
      chk({tag, "_re"}, 64'(sram_read_en), 0);
      chk({tag, "_empty"}, 64'(empty), 1);
      chk({tag, "_full"}, 64'(full), 0);
      chk({tag, "_count"}, 64'(count), 0);
   endtask

   initial begin
      bit found;
      int pushed;
      clear_model();

      // Reset state, with in_vld high to show it is ignored.
      in_vld = 1'b1;
      #12;
      chk_reset_outputs("reset");
      in_vld = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Words 1..5 in order, first out_vld three cycles after first push.
      out_rdy = 1'b1;
      seqv = 1;
      first_push = -1;
      first_vld = -1;
      n_pops = 0;
      push_n(5, 50);
      drain(50);
      chk("latency", 64'(first_vld - first_push), 3);
      chk("pops_five", 64'(n_pops), 5);
      $display("phase fifo order: pops=%0d latency=%0d", n_pops, first_vld - first_push);

      // Fill to capacity with the consumer stalled.
      out_rdy = 1'b0;
      push_n(64, 300);
      repeat (4) cycle();
      chk("fill_count61", 64'(count), 61);
      chk("fill_not_full", 64'(full), 0);
      push_n(3, 20);
      chk("fill_count64", 64'(count), 64);
      chk("fill_full", 64'(full), 1);
      in_vld = 1'b1;
      #1;
      chk("fill_in_rdy", 64'(in_rdy), 0);
      repeat (3) cycle();
      in_vld = 1'b0;
      drain(400);
      $display("phase fill: drained, pops=%0d", n_pops);

      // Contention: backlog present, input and output both streaming.
      out_rdy = 1'b0;
      push_n(8, 50);
      repeat (4) cycle();
      in_vld  = 1'b1;
      out_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = W'(seqv);
         cycle();
         if (did_push) seqv++;
         chk("one_grant", 64'(int'(last_we) + int'(last_re)), 1);
         chk("grant_alternates", 64'(last_we), 64'((i % 2) == 0));
      end
      drain(100);
      $display("phase round robin done");

      // Random traffic across pointer wrap.
      pushed = 0;
      for (int t = 0; t < 2000 && pushed < 70; t++) begin
         in_vld  = ($urandom_range(0, 9) < 8);
         in_data = W'($urandom);
         out_rdy = ($urandom_range(0, 9) < 7);
         cycle();
         if (did_push) pushed++;
      end
      chk("random_pushed", 64'(pushed), 70);
      drain(300);
      $display("phase random: pushed=%0d", pushed);

      // Stall with five words stored.
      out_rdy = 1'b0;
      push_n(5, 30);
      repeat (4) cycle();
      for (int i = 0; i < 10; i++) begin
         chk("stall_count", 64'(count), 2);
         chk("stall_out_vld", 64'(out_vld), 1);
         chk("stall_no_read", 64'(sram_read_en), 0);
         chk("stall_head", 64'(out_data), 64'(model_q[0]));
         cycle();
      end
      $display("phase stall done");

      // Reset asserted while a read grant is active.
      out_rdy = 1'b1;
      found = 0;
      for (int t = 0; t < 10 && !found; t++) begin
         cycle();
         out_rdy = 1'b0;
         if (sram_read_en) found = 1;
      end
      chk("read_grant_seen", 64'(found), 1);
      in_vld = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(posedge clk);
      #1;
      clear_model();
      in_vld = 1'b0;
      rst_n = 1'b1;
      out_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("post_rst_out_vld", 64'(out_vld), 0);
         chk("post_rst_empty", 64'(empty), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
